// File: rtl/instr_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : instr_decode_stage
// Description : Registered RV32I/RV32E decode stage. Owns the register file
//               and drives an ID/EX pipeline register with a valid/ready
//               handshake, flush, load-use stall and illegal flagging.
//               Optional build macro DECODE_BYPASS_EN: register reads see a
//               same-cycle write-back (write-through).
// Revision    : 1.0 - initial release
// ============================================================================
module instr_decode_stage #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,   // 16 (RV32E) or 32 (RV32I)
    parameter int ALU_OP_W = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         instr,
    input  logic [XLEN-1:0]     pc_in,
    input  logic [XLEN-1:0]     next_pc_in,
    input  logic [XLEN-1:0]     reg_write_data,
    input  logic                reg_write_enable,
    input  logic [4:0]          reg_write_addr,
    input  logic                flush,
    input  logic                ex_ready,
    output logic                out_valid,
    output logic [XLEN-1:0]     pc_out,
    output logic [XLEN-1:0]     next_pc_out,
    output logic                rd_write_enable,
    output logic [4:0]          rd_write_addr,
    output logic [4:0]          rs1_addr,
    output logic [4:0]          rs2_addr,
    output logic                res_src,
    output logic                branch,
    output logic                jump,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                alu_input_conf,
    output logic [XLEN-1:0]     imm,
    output logic [XLEN-1:0]     rs1_data,
    output logic [XLEN-1:0]     rs2_data,
    output logic                illegal
);

    localparam int         c_AW        = (NUM_REGS > 16) ? 5 : 4;
    localparam logic [5:0] c_NREGS     = 6'(NUM_REGS);
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] c_OP_OP     = 7'b0110011;

    logic [XLEN-1:0] r_regs [NUM_REGS];

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [4:0]  w_rd, w_rs1, w_rs2;
    logic        w_known, w_use_rd, w_use_rs1, w_use_rs2;
    logic        w_is_load, w_is_branch, w_is_jump, w_imm_sel, w_alt;
    logic [1:0]  w_cls;
    logic [2:0]  w_f3_eff;
    logic [31:0] w_imm32;
    logic [4:0]  w_rd_addr, w_rs1_addr, w_rs2_addr;
    logic        w_bad_idx, w_illegal;
    logic        w_rs1_in, w_rs2_in, w_wr_ok;
    logic [XLEN-1:0] w_rs1_data, w_rs2_data;
    logic [5:0]  w_alu_op6;
    logic        w_stall, w_accept;

    assign w_opcode = instr[6:0];
    assign w_funct3 = instr[14:12];
    assign w_rd     = instr[11:7];
    assign w_rs1    = instr[19:15];
    assign w_rs2    = instr[24:20];

    // Opcode decode: operand usage, control class, ALU class and immediate format
    always_comb begin
        w_known     = 1'b0;
        w_use_rd    = 1'b0;
        w_use_rs1   = 1'b0;
        w_use_rs2   = 1'b0;
        w_is_load   = 1'b0;
        w_is_branch = 1'b0;
        w_is_jump   = 1'b0;
        w_imm_sel   = 1'b0;
        w_alt       = 1'b0;
        w_cls       = 2'b00;
        w_f3_eff    = 3'b000;
        w_imm32     = 32'd0;
        case (w_opcode)
            c_OP_LUI: begin
                w_known = 1'b1; w_use_rd = 1'b1; w_imm_sel = 1'b1; w_cls = 2'b11;
                w_imm32 = {instr[31:12], 12'd0};
            end
            c_OP_AUIPC: begin
                w_known = 1'b1; w_use_rd = 1'b1; w_imm_sel = 1'b1; w_cls = 2'b10;
                w_imm32 = {instr[31:12], 12'd0};
            end
            c_OP_JAL: begin
                w_known = 1'b1; w_use_rd = 1'b1; w_imm_sel = 1'b1; w_cls = 2'b10;
                w_is_jump = 1'b1;
                w_imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            c_OP_JALR: begin
                w_known = 1'b1; w_use_rd = 1'b1; w_use_rs1 = 1'b1; w_imm_sel = 1'b1;
                w_cls = 2'b10; w_is_jump = 1'b1;
                w_imm32 = {{20{instr[31]}}, instr[31:20]};
            end
            c_OP_BRANCH: begin
                w_known = 1'b1; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_cls = 2'b01;
                w_f3_eff = w_funct3; w_is_branch = 1'b1;
                w_imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            c_OP_LOAD: begin
                w_known = 1'b1; w_use_rd = 1'b1; w_use_rs1 = 1'b1; w_imm_sel = 1'b1;
                w_cls = 2'b10; w_is_load = 1'b1;
                w_imm32 = {{20{instr[31]}}, instr[31:20]};
            end
            c_OP_STORE: begin
                w_known = 1'b1; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_imm_sel = 1'b1;
                w_cls = 2'b10;
                w_imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            c_OP_OPIMM: begin
                w_known = 1'b1; w_use_rd = 1'b1; w_use_rs1 = 1'b1; w_imm_sel = 1'b1;
                w_f3_eff = w_funct3; w_alt = (w_funct3 == 3'b101) & instr[30];
                w_imm32 = {{20{instr[31]}}, instr[31:20]};
            end
            c_OP_OP: begin
                w_known = 1'b1; w_use_rd = 1'b1; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
                w_f3_eff = w_funct3; w_alt = instr[30];
            end
            default: ;
        endcase
    end

    // Unused register fields are reported as x0 so EX never forwards on them
    assign w_rd_addr  = w_use_rd  ? w_rd  : 5'd0;
    assign w_rs1_addr = w_use_rs1 ? w_rs1 : 5'd0;
    assign w_rs2_addr = w_use_rs2 ? w_rs2 : 5'd0;

    assign w_rs1_in  = ({1'b0, w_rs1_addr} < c_NREGS);
    assign w_rs2_in  = ({1'b0, w_rs2_addr} < c_NREGS);
    assign w_bad_idx = ({1'b0, w_rd_addr} >= c_NREGS) | ~w_rs1_in | ~w_rs2_in;
    assign w_illegal = ~w_known | w_bad_idx;
    assign w_alu_op6 = {w_alt, w_f3_eff, w_cls};

    // Register-file read ports; x0 and out-of-range indices read as zero
    always_comb begin
        w_rs1_data = '0;
        w_rs2_data = '0;
        if ((w_rs1_addr != 5'd0) && w_rs1_in) w_rs1_data = r_regs[w_rs1_addr[c_AW-1:0]];
        if ((w_rs2_addr != 5'd0) && w_rs2_in) w_rs2_data = r_regs[w_rs2_addr[c_AW-1:0]];
`ifdef DECODE_BYPASS_EN
        if (reg_write_enable && (w_rs1_addr != 5'd0) && w_rs1_in && (reg_write_addr == w_rs1_addr))
            w_rs1_data = reg_write_data;
        if (reg_write_enable && (w_rs2_addr != 5'd0) && w_rs2_in && (reg_write_addr == w_rs2_addr))
            w_rs2_data = reg_write_data;
`endif
    end

    assign w_wr_ok = reg_write_enable && (reg_write_addr != 5'd0) &&
                     ({1'b0, reg_write_addr} < c_NREGS);

    // Register-file write port (flush does not block write-back)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else if (w_wr_ok) begin
            r_regs[reg_write_addr[c_AW-1:0]] <= reg_write_data;
        end
    end

    // A load in the output register whose rd feeds the incoming instruction
    // must not be decoded yet: its data is not available until after memory.
    assign w_stall  = out_valid & res_src & (rd_write_addr != 5'd0) & in_valid &
                      ((w_rs1_addr == rd_write_addr) | (w_rs2_addr == rd_write_addr));
    assign in_ready = flush | ((~out_valid | ex_ready) & ~w_stall);
    assign w_accept = in_valid & in_ready & ~flush;

    // ID/EX pipeline register: flush kills, back-pressure holds, accept loads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid       <= 1'b0;
            pc_out          <= '0;
            next_pc_out     <= '0;
            rd_write_enable <= 1'b0;
            rd_write_addr   <= 5'd0;
            rs1_addr        <= 5'd0;
            rs2_addr        <= 5'd0;
            res_src         <= 1'b0;
            branch          <= 1'b0;
            jump            <= 1'b0;
            alu_op          <= '0;
            alu_input_conf  <= 1'b0;
            imm             <= '0;
            rs1_data        <= '0;
            rs2_data        <= '0;
            illegal         <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (w_accept) begin
            out_valid       <= 1'b1;
            pc_out          <= pc_in;
            next_pc_out     <= next_pc_in;
            rd_write_enable <= w_use_rd & (w_rd != 5'd0) & ~w_illegal;
            rd_write_addr   <= w_rd_addr;
            rs1_addr        <= w_rs1_addr;
            rs2_addr        <= w_rs2_addr;
            res_src         <= w_is_load;
            branch          <= w_is_branch & ~w_illegal;
            jump            <= w_is_jump & ~w_illegal;
            alu_op          <= ALU_OP_W'(w_alu_op6);
            alu_input_conf  <= w_imm_sel;
            imm             <= XLEN'($signed(w_imm32));
            rs1_data        <= w_rs1_data;
            rs2_data        <= w_rs2_data;
            illegal         <= w_illegal;
        end else if (!out_valid || ex_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire
